// File: rtl/sram_vec_fetch.sv
// sram_vec_fetch: Avalon-MM read master that copies a contiguous block of
// SRAM words into a small FIFO and presents them on a valid/ready stream.
// Build option: define SRAM_FETCH_STALL_CNT_EN to add the stall_cycles
// output, which counts cycles spent waiting on m_waitrequest.
//
// state | meaning
// IDLE  | no transfer; waits for start
// FETCH | issuing reads, pushing returned words into the FIFO
// DRAIN | all words read; waits for the consumer to empty the FIFO
// FLUSH | aborting; lets an outstanding read finish, then drops FIFO contents
module sram_vec_fetch #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic [BE_WIDTH-1:0]   m_byteenable,
    output logic                  m_read,
    output logic                  m_write,
    output logic [DATA_WIDTH-1:0] m_writedata,
    input  logic [DATA_WIDTH-1:0] m_readdata,
    input  logic                  m_waitrequest,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef SRAM_FETCH_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CNT_W = FIFO_AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] rem_q, rem_d;
    logic                  rd_q, rd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] rem_next;
    logic [CNT_W-1:0]      count_next;

    // Handshake qualifiers; data returned while aborting is never pushed.
    assign accept     = rd_q & ~m_waitrequest;
    assign pop        = out_valid & out_ready;
    assign push       = (state_q == ST_FETCH) & accept & ~abort;
    assign rem_next   = accept ? rem_q - 1'b1 : rem_q;
    assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

    // Next-state and next-register values; m_read held until its read is accepted.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        rd_d      = rd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = aborted_q;
        flush     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        addr_d    = base_addr;
                        rem_d     = word_count;
                        aborted_d = 1'b0;
                        busy_d    = 1'b1;
                        rd_d      = 1'b1;
                        state_d   = ST_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    rd_d    = rd_q & ~accept;
                    state_d = ST_FLUSH;
                end else begin
                    if (accept) begin
                        addr_d = addr_q + 1'b1;
                        rem_d  = rem_next;
                    end
                    rd_d = (rem_next != '0) && (count_next < CNT_W'(DEPTH));
                    if (rem_next == '0) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_FLUSH;
                end else if (count_next == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                rd_d = rd_q & ~accept;
                if (!rd_q) begin
                    flush     = 1'b1;
                    aborted_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_next;
            wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
            rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
        end
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset because out_data is masked when empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= m_readdata;
        end
    end

`ifdef SRAM_FETCH_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        stall_clr;

    assign stall_clr = (state_q == ST_IDLE) & start;

    // Saturating count of cycles with a read stalled by the arbiter.
    always_ff @(posedge clock) begin
        if (reset || stall_clr) begin
            stall_q <= '0;
        end else if (rd_q && m_waitrequest && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign m_read       = rd_q;
    assign m_address    = addr_q;
    assign m_byteenable = rd_q ? {BE_WIDTH{1'b1}} : {BE_WIDTH{1'b0}};
    assign m_write      = 1'b0;
    assign m_writedata  = '0;
    assign out_valid    = (count_q != '0);
    assign out_data     = out_valid ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_sram_vec_fetch.sv
// Directed testbench for sram_vec_fetch; memory model returns addr ^ 0xC3A5.
module tb_sram_vec_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] base_addr;
    logic [19:0] word_count;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [19:0] m_address;
    logic [1:0]  m_byteenable;
    logic        m_read;
    logic        m_write;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata;
    logic        m_waitrequest;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef SRAM_FETCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    sram_vec_fetch dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .m_address     (m_address),
        .m_byteenable  (m_byteenable),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
`ifdef SRAM_FETCH_STALL_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    assign m_readdata = m_address[15:0] ^ 16'hC3A5;

    function automatic logic [15:0] dexp(input logic [19:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic do_start(input logic [19:0] b, input logic [19:0] n);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        int   n;
        int   idx;
        logic seen;

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        abort = 1'b0; m_waitrequest = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_aborted", 32'(aborted), 0);
        chk("rst_mread", 32'(m_read), 0);
        chk("rst_maddr", 32'(m_address), 0);
        chk("rst_be", 32'(m_byteenable), 0);
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_odata", 32'(out_data), 0);
        reset = 1'b0;
        tick();

        // Basic 4-word transfer, 1 word/cycle
        do_start(20'h00010, 20'd4);
        chk("t1_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk("t1_mread", 32'(m_read), 1);
            chk("t1_be", 32'(m_byteenable), 32'h3);
            chk("t1_addr", 32'(m_address), 32'h10 + i);
            if (i > 0) chk("t1_data", 32'(out_data), 32'(dexp(20'h10 + 20'(i - 1))));
        end
        tick();
        chk("t1_mread_off", 32'(m_read), 0);
        chk("t1_last_data", 32'(out_data), 32'(dexp(20'h13)));
        chk("t1_done_early", 32'(done), 0);
        tick();
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_off", 32'(busy), 0);
        chk("t1_empty", 32'(out_valid), 0);
        tick();
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_mwrite", 32'(m_write), 0);

        // 5-cycle stall on the second read
        do_start(20'h00020, 20'd3);
        chk("t2_addr0", 32'(m_address), 32'h20);
        tick();
        m_waitrequest = 1'b1;
        chk("t2_data0", 32'(out_data), 32'(dexp(20'h20)));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_hold_read", 32'(m_read), 1);
            chk("t2_hold_addr", 32'(m_address), 32'h21);
            chk("t2_no_dup", 32'(out_valid), 0);
        end
        m_waitrequest = 1'b0;
        tick();
        chk("t2_data1", 32'(out_data), 32'(dexp(20'h21)));
        tick();
        chk("t2_data2", 32'(out_data), 32'(dexp(20'h22)));
        tick();
        chk("t2_done", 32'(done), 1);
`ifdef SRAM_FETCH_STALL_CNT_EN
        chk("t2_stall_cycles", stall_cycles, 32'd5);
`endif
        tick();

        // Backpressure: FIFO fills at 8, then the remaining 4 words follow
        out_ready = 1'b0;
        do_start(20'h00040, 20'd12);
        n = 0;
        repeat (14) begin
            if (m_read) n++;
            tick();
        end
        chk("t3_reads_full", 32'(n), 32'd8);
        chk("t3_mread_off", 32'(m_read), 0);
        chk("t3_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        idx  = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (out_valid) begin
                chk("t3_word", 32'(out_data), 32'(dexp(20'h40 + 20'(idx))));
                idx++;
            end
            tick();
        end
        chk("t3_done", 32'(seen), 1);
        chk("t3_count", 32'(idx), 32'd12);
        tick();

        // Address wrap
        do_start(20'hFFFFE, 20'd3);
        chk("t4_addr0", 32'(m_address), 32'hFFFFE);
        tick();
        chk("t4_addr1", 32'(m_address), 32'hFFFFF);
        tick();
        chk("t4_addr2", 32'(m_address), 32'h00000);
        wait_done(10, "t4_done");
        tick();

        // Abort while a read is stalled
        out_ready = 1'b0;
        do_start(20'h00080, 20'd6);
        tick();
        chk("t5_valid", 32'(out_valid), 1);
        m_waitrequest = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t5_hold_read", 32'(m_read), 1);
            chk("t5_hold_addr", 32'(m_address), 32'h81);
            chk("t5_no_done", 32'(done), 0);
            tick();
        end
        m_waitrequest = 1'b0;
        tick();
        chk("t5_read_off", 32'(m_read), 0);
        chk("t5_done_early", 32'(done), 0);
        tick();
        chk("t5_done", 32'(done), 1);
        chk("t5_aborted", 32'(aborted), 1);
        chk("t5_flushed", 32'(out_valid), 0);
        chk("t5_busy_off", 32'(busy), 0);
        tick();
        chk("t5_done_pulse", 32'(done), 0);
        chk("t5_sticky", 32'(aborted), 1);
        out_ready = 1'b1;
        do_start(20'h00090, 20'd1);
        chk("t5_aborted_clr", 32'(aborted), 0);
        chk("t5_busy2", 32'(busy), 1);
        wait_done(10, "t5_done2");
        tick();

        // Zero-length transfer
        do_start(20'h00100, 20'd0);
        chk("t6_done", 32'(done), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_mread", 32'(m_read), 0);
        tick();
        chk("t6_done_pulse", 32'(done), 0);

        // Reset in the middle of a fetch
        do_start(20'h00200, 20'd8);
        tick();
        chk("t7_pre_read", 32'(m_read), 1);
        reset = 1'b1;
        tick();
        chk("t7_mread", 32'(m_read), 0);
        chk("t7_maddr", 32'(m_address), 0);
        chk("t7_be", 32'(m_byteenable), 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_valid", 32'(out_valid), 0);
        chk("t7_odata", 32'(out_data), 0);
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
